// File: rtl/clock_pkg.sv
// Shared types and constants for the clock/alarm blocks.
package clock_pkg;

  localparam int unsigned BCD_W    = 4;
  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    SET_H   = 3'd1,
    SET_M   = 3'd2,
    ARMED   = 3'd3,
    RINGING = 3'd4
  } alarm_state_t;

endpackage

// File: rtl/alarm_ctrl_if.sv
// Key/time inputs and alarm outputs of alarm_ctrl, grouped as one bus.
interface alarm_ctrl_if;
  import clock_pkg::*;

  bcd_t         digits [6];
  logic         alarm_key;
  logic         inc;
  logic         dec;
  bcd_t         alarm_digits [4];
  alarm_state_t alarm_state;
  logic         buzzer;

  modport master (
    output digits, alarm_key, inc, dec,
    input  alarm_digits, alarm_state, buzzer
  );

  modport slave (
    input  digits, alarm_key, inc, dec,
    output alarm_digits, alarm_state, buzzer
  );
endinterface

// File: rtl/bcd_updown.sv
// Two-digit BCD up/down counter wrapping between 00 and MAX.
module bcd_updown
  import clock_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic inc,
  input  logic dec,
  output bcd_t tens,
  output bcd_t ones
);

  localparam bcd_t MAX_TENS = 4'(MAX / 10);
  localparam bcd_t MAX_ONES = 4'(MAX % 10);

  // Simultaneous inc and dec cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens <= '0;
      ones <= '0;
    end else if (en && (inc ^ dec)) begin
      if (inc) begin
        if (tens == MAX_TENS && ones == MAX_ONES) begin
          tens <= '0;
          ones <= '0;
        end else if (ones == 4'd9) begin
          ones <= '0;
          tens <= tens + 4'(1);
        end else begin
          ones <= ones + 4'(1);
        end
      end else begin
        if (tens == 4'd0 && ones == 4'd0) begin
          tens <= MAX_TENS;
          ones <= MAX_ONES;
        end else if (ones == 4'd0) begin
          ones <= 4'd9;
          tens <= tens - 4'(1);
        end else begin
          ones <= ones - 4'(1);
        end
      end
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm setting, arming and ringing control with a square-wave buzzer.
module alarm_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned BEEP_HALF    = 25000,
  parameter int unsigned RING_SECONDS = 60
) (
  input  logic         clk100khz,
  input  logic         rst,
  alarm_ctrl_if.slave  bus
);

  localparam int unsigned RING_CYCLES = RING_SECONDS * TICK_DIV;
  localparam int unsigned RING_W      = $clog2(RING_CYCLES + 1);
  localparam int unsigned BEEP_W      = $clog2(BEEP_HALF + 1);

  alarm_state_t      state;
  logic              buzzer_q;
  logic              match_q;
  logic [RING_W-1:0] ring_cnt;
  logic [BEEP_W-1:0] beep_cnt;

  bcd_t h_tens, h_ones, m_tens, m_ones;
  logic match;
  logic any_key;

  bcd_updown #(.MAX(HOUR_MAX)) u_hour (
    .clk  (clk100khz),
    .rst  (rst),
    .en   (state == SET_H),
    .inc  (bus.inc),
    .dec  (bus.dec),
    .tens (h_tens),
    .ones (h_ones)
  );

  bcd_updown #(.MAX(MIN_MAX)) u_min (
    .clk  (clk100khz),
    .rst  (rst),
    .en   (state == SET_M),
    .inc  (bus.inc),
    .dec  (bus.dec),
    .tens (m_tens),
    .ones (m_ones)
  );

  assign match = (bus.digits[0] == h_tens) && (bus.digits[1] == h_ones) &&
                 (bus.digits[2] == m_tens) && (bus.digits[3] == m_ones) &&
                 (bus.digits[4] == 4'd0)   && (bus.digits[5] == 4'd0);

  assign any_key = bus.alarm_key | bus.inc | bus.dec;

  // Mode stepping, match edge detection, ring timeout and beep generation.
  always_ff @(posedge clk100khz) begin
    if (rst) begin
      state    <= OFF;
      buzzer_q <= 1'b0;
      match_q  <= 1'b0;
      ring_cnt <= '0;
      beep_cnt <= '0;
    end else begin
      match_q <= match;
      case (state)
        OFF:   if (bus.alarm_key) state <= SET_H;
        SET_H: if (bus.alarm_key) state <= SET_M;
        SET_M: if (bus.alarm_key) state <= ARMED;
        ARMED: begin
          if (bus.alarm_key) begin
            state <= OFF;
          end else if (match && !match_q) begin
            state    <= RINGING;
            buzzer_q <= 1'b1;
            ring_cnt <= '0;
            beep_cnt <= '0;
          end
        end
        RINGING: begin
          if (any_key || ring_cnt == RING_W'(RING_CYCLES - 1)) begin
            state    <= ARMED;
            buzzer_q <= 1'b0;
          end else begin
            ring_cnt <= ring_cnt + RING_W'(1);
            if (beep_cnt == BEEP_W'(BEEP_HALF - 1)) begin
              beep_cnt <= '0;
              buzzer_q <= ~buzzer_q;
            end else begin
              beep_cnt <= beep_cnt + BEEP_W'(1);
            end
          end
        end
        default: begin
          state    <= OFF;
          buzzer_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alarm_digits[0] = h_tens;
  assign bus.alarm_digits[1] = h_ones;
  assign bus.alarm_digits[2] = m_tens;
  assign bus.alarm_digits[3] = m_ones;
  assign bus.alarm_state     = state;
  assign bus.buzzer          = buzzer_q;

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, clk100khz cycles per second.
REQ-002 SHALL have parameter BEEP_HALF, default 25000, cycles per buzzer half-period.
REQ-003 SHALL have parameter RING_SECONDS, default 60, maximum ring duration in seconds.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk100khz input 1: system clock, 100 kHz.
REQ-006 SHALL have port rst input 1: synchronous active-high reset.
REQ-007 SHALL have port digits input 6x4: current time BCD, index 0..5 = msb_h, lsb_h, msb_m, lsb_m, msb_s, lsb_s.
REQ-008 SHALL have port alarm_key input 1: debounced single-cycle pulse, alarm mode step.
REQ-009 SHALL have port inc input 1: debounced single-cycle increase pulse.
REQ-010 SHALL have port dec input 1: debounced single-cycle decrease pulse.
REQ-011 SHALL have port alarm_digits output 4x4: alarm time BCD, index 0..3 = msb_h, lsb_h, msb_m, lsb_m.
REQ-012 SHALL have port alarm_state output 3: current FSM state encoding.
REQ-013 SHALL have port buzzer output 1: square-wave buzzer drive.

Function
REQ-014 SHALL implement states OFF, SET_H, SET_M, ARMED, RINGING.
REQ-015 alarm_key SHALL step OFF->SET_H->SET_M->ARMED->OFF, one step per pulse.
REQ-016 In SET_H, inc/dec SHALL change alarm hour by one in BCD, range 00..23, wrapping 23->00 on inc and 00->23 on dec.
REQ-017 In SET_M, inc/dec SHALL change alarm minute by one in BCD, range 00..59, wrapping 59->00 and 00->59.
REQ-018 inc and dec asserted in the same cycle SHALL leave the alarm value unchanged.
REQ-019 inc/dec outside SET_H/SET_M SHALL not change the alarm value, except as in REQ-023.
REQ-020 alarm_digits SHALL show the registered alarm value in every state, updating the cycle after the accepted key.
REQ-021 The match condition SHALL be: digits[0..3] equal alarm_digits and digits[4..5] equal 0,0.
REQ-022 ARMED SHALL enter RINGING on the cycle after a rising edge of match; a match held high SHALL not retrigger.
REQ-023 In RINGING, any of alarm_key, inc or dec SHALL return to ARMED next cycle, silence buzzer, and have no other effect.
REQ-024 RINGING SHALL return to ARMED after RING_SECONDS x TICK_DIV cycles.
REQ-025 Ring duration SHALL come from an internal counter, not from digits.
REQ-026 buzzer SHALL be 0 outside RINGING.
REQ-027 In RINGING, buzzer SHALL start at 1 and toggle every BEEP_HALF cycles.
REQ-028 Entering SET_H or SET_M from any state SHALL not alter the stored alarm value.

Reset
REQ-029 While rst is high at a clock edge, the block SHALL enter OFF.
REQ-030 Reset SHALL set alarm_digits to 0,0,0,0 and buzzer to 0.
REQ-031 Reset SHALL clear the ring, beep and edge-detect registers.
REQ-032 Reset mid-RINGING SHALL silence buzzer on the first clock edge where rst is sampled high.
REQ-033 Key pulses coincident with rst SHALL be ignored.

Structure
REQ-034 Shared package clock_pkg SHALL hold the bcd_t (4-bit) typedef.
REQ-035 clock_pkg SHALL hold the alarm_state_t enum.
REQ-036 clock_pkg SHALL hold constants HOUR_MAX=23 and MIN_MAX=59.
REQ-037 One sub-module, bcd_updown, SHALL implement a two-digit BCD up/down wrap counter with its maximum as a parameter.
REQ-038 alarm_ctrl SHALL instantiate bcd_updown twice: one for hours, one for minutes.

Verification
REQ-039 Reset, then alarm_key x1 and dec x1 -> state SET_H, alarm_digits=2,3,0,0.
REQ-040 In SET_M at 59, inc -> 0,0; inc and dec in the same cycle -> value unchanged.
REQ-041 Alarm 07:30 ARMED, digits sweep 07:29:59 -> 07:30:00 -> buzzer 1 within 2 cycles, toggling every BEEP_HALF cycles.
REQ-042 RINGING with no key -> ARMED and buzzer 0 exactly RING_SECONDS x TICK_DIV cycles after entry; no retrigger while digits stay 07:30:00.
REQ-043 RINGING, inc pulse -> ARMED next cycle, buzzer 0, alarm still 07:30.
REQ-044 rst during RINGING -> state OFF, buzzer 0, alarm_digits=0,0,0,0 on the next edge.
